// File: rtl/ov7670_config_seq_if.sv
// ----------------------------------------------------------------------------
// ov7670_config_seq_if
// Command channel between the OV7670 config sequencer and the SCCB master.
//   cmd_valid  master->slave  write request
//   cmd_ready  slave->master  request accepted
//   cmd_reg    master->slave  register address of the write
//   cmd_data   master->slave  register value of the write
//   cmd_done   slave->master  one-cycle pulse when the write finishes
//   cmd_nack   slave->master  qualifies cmd_done; 1 = camera did not ACK
// ----------------------------------------------------------------------------
interface ov7670_config_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_data;
    logic       cmd_done;
    logic       cmd_nack;

    modport master (
        output cmd_valid, cmd_reg, cmd_data,
        input  cmd_ready, cmd_done, cmd_nack
    );

    modport slave (
        input  cmd_valid, cmd_reg, cmd_data,
        output cmd_ready, cmd_done, cmd_nack
    );
endinterface

// File: rtl/ov7670_config_seq.sv
// ----------------------------------------------------------------------------
// ov7670_config_seq
// Walks the camera-init ROM from address 0 on start, issuing one SCCB register
// write per entry, honouring delay / end-of-list markers and retrying NACKs.
//   clk, rst        clock, synchronous active-high reset
//   start_i         pulse that begins a configuration pass
//   rom_addr_o      registered ROM address (data valid one clk later)
//   rom_data_i      ROM word: [15:8] register, [7:0] value
//   cmd_if          command channel to the SCCB master (master modport)
//   busy_o          pass in progress
//   done_o          pass completed successfully (sticky)
//   error_o         retries exhausted (sticky); rom_addr_o holds failing entry
//   write_count_o   acknowledged writes in the current pass (saturating)
// ----------------------------------------------------------------------------
module ov7670_config_seq #(
    parameter int unsigned ADDRW        = 8,
    parameter int unsigned DELAY_CYCLES = 250000,
    parameter int unsigned MAX_RETRY    = 3,
    parameter logic [15:0] END_WORD     = 16'hFFFF,
    parameter logic [15:0] DELAY_WORD   = 16'hFFF0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    output logic [ADDRW-1:0]          rom_addr_o,
    input  logic [15:0]               rom_data_i,
    ov7670_config_seq_if.master       cmd_if,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o,
    output logic [ADDRW:0]            write_count_o
);

    localparam int unsigned DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [DW-1:0]    DLY_LOAD  = DW'(DELAY_CYCLES - 1);
    localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [ADDRW-1:0] ADDR_LAST = {ADDRW{1'b1}};
    localparam logic [ADDRW:0]   WC_MAX    = {1'b1, {ADDRW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_DONE, S_DELAY, S_DONE, S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [ADDRW-1:0] rom_addr_q, rom_addr_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [7:0]       cmd_reg_q, cmd_reg_d;
    logic [7:0]       cmd_data_q, cmd_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [ADDRW:0]   wc_q, wc_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [DW-1:0]    dly_q, dly_d;

    logic start_ok_c;
    logic handshake_c;
    logic ack_c;
    logic nack_c;
    logic advance_c;
    logic last_c;

    // Event decode shared by the next-state and output processes
    always_comb begin
        start_ok_c  = start_i && (state_q inside {S_IDLE, S_DONE, S_ERR});
        handshake_c = cmd_valid_q && cmd_if.cmd_ready;
        ack_c       = (state_q == S_WAIT_DONE) && cmd_if.cmd_done && !cmd_if.cmd_nack;
        nack_c      = (state_q == S_WAIT_DONE) && cmd_if.cmd_done &&  cmd_if.cmd_nack;
        advance_c   = ack_c || ((state_q == S_DELAY) && (dly_q == '0));
        last_c      = (rom_addr_q == ADDR_LAST);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_reg_q   <= '0;
            cmd_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            wc_q        <= '0;
            retry_q     <= '0;
            dly_q       <= '0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_reg_q   <= cmd_reg_d;
            cmd_data_q  <= cmd_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            wc_q        <= wc_d;
            retry_q     <= retry_d;
            dly_q       <= dly_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start_ok_c) state_d = S_FETCH;
            S_FETCH:               state_d = S_DECODE;
            S_DECODE: begin
                if (rom_data_i == END_WORD)        state_d = S_DONE;
                else if (rom_data_i == DELAY_WORD) state_d = S_DELAY;
                else                               state_d = S_ISSUE;
            end
            S_ISSUE:     if (handshake_c) state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (ack_c)                        state_d = last_c ? S_DONE : S_FETCH;
                else if (nack_c && retry_q < RETRY_MAX) state_d = S_ISSUE;
                else if (nack_c)                  state_d = S_ERR;
            end
            S_DELAY:     if (advance_c) state_d = last_c ? S_DONE : S_FETCH;
            default:     state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        rom_addr_d = rom_addr_q;
        cmd_reg_d  = cmd_reg_q;
        cmd_data_d = cmd_data_q;
        wc_d       = wc_q;
        retry_d    = retry_q;
        dly_d      = dly_q;

        if (start_ok_c) begin
            rom_addr_d = '0;
            retry_d    = '0;
            wc_d       = '0;
        end

        if (state_q == S_DECODE) begin
            if (rom_data_i == DELAY_WORD) begin
                dly_d = DLY_LOAD;
            end else if (rom_data_i != END_WORD) begin
                cmd_reg_d  = rom_data_i[15:8];
                cmd_data_d = rom_data_i[7:0];
            end
        end

        if (state_q == S_DELAY && dly_q != '0) begin
            dly_d = dly_q - DW'(1);
        end

        if (ack_c) begin
            retry_d = '0;
            if (wc_q != WC_MAX) wc_d = wc_q + (ADDRW+1)'(1);
        end else if (nack_c && retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
        end

        // Last entry terminates the list implicitly, so the address stays put
        if (advance_c && !last_c) begin
            rom_addr_d = rom_addr_q + ADDRW'(1);
        end

        cmd_valid_d = (state_d == S_ISSUE);
        busy_d      = !(state_d inside {S_IDLE, S_DONE, S_ERR});
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERR);
    end

    assign rom_addr_o       = rom_addr_q;
    assign cmd_if.cmd_valid = cmd_valid_q;
    assign cmd_if.cmd_reg   = cmd_reg_q;
    assign cmd_if.cmd_data  = cmd_data_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign error_o          = error_q;
    assign write_count_o    = wc_q;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// ----------------------------------------------------------------------------
// tb_ov7670_config_seq
// Scoreboard bench: tests push expected (reg,data) writes into a queue; a
// monitor compares every presented command against the queue head and pops on
// handshake. A responder models the SCCB master (ready stall, done 3 cycles
// after accept, scripted NACKs). Timing within a negedge: tests drive at +0,
// responder at +1, monitor at +2, status checks at +3.
// ----------------------------------------------------------------------------
module tb_ov7670_config_seq;

    localparam int unsigned ADDRW        = 3;
    localparam int unsigned DELAY_CYCLES = 5;
    localparam int unsigned MAX_RETRY    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [ADDRW-1:0] rom_addr;
    logic [15:0]      rom_data;
    logic             busy, done, error;
    logic [ADDRW:0]   wc;

    ov7670_config_seq_if cmd_if ();

    ov7670_config_seq #(
        .ADDRW       (ADDRW),
        .DELAY_CYCLES(DELAY_CYCLES),
        .MAX_RETRY   (MAX_RETRY),
        .END_WORD    (16'hFFFF),
        .DELAY_WORD  (16'hFFF0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .cmd_if       (cmd_if.master),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .write_count_o(wc)
    );

    always #5 clk = ~clk;

    // Synchronous config ROM
    logic [15:0] rom [8];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int hs_count = 0;
    int stall    = 0;
    int done_cnt = 0;
    logic [15:0] exp_q [$];
    bit          nack_q [$];
    int          rise_cyc [$];
    int          done_cyc [$];
    logic        prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SCCB master model
    initial begin
        cmd_if.cmd_ready = 1'b0;
        cmd_if.cmd_done  = 1'b0;
        cmd_if.cmd_nack  = 1'b0;
        forever begin
            @(negedge clk); #1;
            cyc++;
            cmd_if.cmd_done = 1'b0;
            cmd_if.cmd_nack = 1'b0;
            if (rst) begin
                done_cnt         = 0;
                cmd_if.cmd_ready = 1'b0;
            end else begin
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) begin
                        cmd_if.cmd_done = 1'b1;
                        cmd_if.cmd_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
                        done_cyc.push_back(cyc);
                    end
                end
                if (cmd_if.cmd_valid && stall > 0) begin
                    stall--;
                    cmd_if.cmd_ready = 1'b0;
                end else begin
                    cmd_if.cmd_ready = 1'b1;
                end
                if (cmd_if.cmd_valid && cmd_if.cmd_ready) done_cnt = 3;
            end
        end
    end

    // Monitor: every presented command must match the scoreboard head
    initial begin
        forever begin
            @(negedge clk); #2;
            if (!rst && cmd_if.cmd_valid) begin
                if (!prev_valid) rise_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_cmd: got reg=%h data=%h expected no write",
                             cmd_if.cmd_reg, cmd_if.cmd_data);
                end else if ({cmd_if.cmd_reg, cmd_if.cmd_data} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL cmd_payload: got %h%h expected %h",
                             cmd_if.cmd_reg, cmd_if.cmd_data, exp_q[0]);
                end
                if (cmd_if.cmd_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    hs_count++;
                end
            end
            prev_valid = cmd_if.cmd_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic flush;
        exp_q.delete();
        nack_q.delete();
        rise_cyc.delete();
        done_cyc.delete();
        hs_count = 0;
        stall    = 0;
    endtask

    task automatic fill_rom(input logic [15:0] w);
        for (int i = 0; i < 8; i++) rom[i] = w;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; #3;
        chk({tag, "_rst_valid"}, 32'(cmd_if.cmd_valid), 0);
        chk({tag, "_rst_busy"},  32'(busy), 0);
        chk({tag, "_rst_done"},  32'(done), 0);
        chk({tag, "_rst_error"}, 32'(error), 0);
        chk({tag, "_rst_wc"},    32'(wc), 0);
        chk({tag, "_rst_addr"},  32'(rom_addr), 0);
        chk({tag, "_rst_regdat"}, 32'({cmd_if.cmd_reg, cmd_if.cmd_data}), 0);
        flush();
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #3;
    endtask

    // Start a pass, optionally re-pulse start after N handshakes, wait for idle
    task automatic run_pass(input string tag, input int restart_after_hs);
        bit idle = 1'b0;
        bit sent = 1'b0;
        pulse_start();
        chk({tag, "_busy_on"}, 32'(busy), 1);
        chk({tag, "_done_clr"}, 32'(done), 0);
        for (int i = 0; i < 2000 && !idle; i++) begin
            if (!busy) idle = 1'b1;
            else begin
                if (restart_after_hs >= 0 && !sent && hs_count >= restart_after_hs) begin
                    start = 1'b1;
                    sent  = 1'b1;
                end
                @(negedge clk);
                start = 1'b0;
                #3;
            end
        end
        if (!idle) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got busy=1 expected busy=0", tag);
        end
    endtask

    task automatic end_checks(input string tag, input int e_done, input int e_err,
                              input int e_wc, input int e_hs);
        chk({tag, "_done"},  32'(done), 32'(e_done));
        chk({tag, "_error"}, 32'(error), 32'(e_err));
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_wc"},    32'(wc), 32'(e_wc));
        chk({tag, "_hs"},    32'(hs_count), 32'(e_hs));
        chk({tag, "_pend"},  32'(exp_q.size()), 0);
    endtask

    task automatic wait_hs(input string tag, input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk); #3;
            if (hs_count >= n) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_wait_hs: got %0d expected %0d", tag, hs_count, n);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        fill_rom(16'hFFFF);
        do_reset("init");

        // Two plain writes then END
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
        run_pass("basic", -1);
        end_checks("basic", 1, 0, 2, 2);
        chk("basic_addr", 32'(rom_addr), 2);
        flush();

        // Delay entry: done of write 0 to valid of write 1 = FETCH+DECODE+5 DELAY+FETCH+DECODE+1
        fill_rom(16'hFFFF);
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h4010; rom[3] = 16'hFFFF;
        exp_q.push_back(16'h1280); exp_q.push_back(16'h4010);
        run_pass("delay", -1);
        end_checks("delay", 1, 0, 2, 2);
        if (rise_cyc.size() >= 2 && done_cyc.size() >= 1)
            chk("delay_gap", 32'(rise_cyc[1] - done_cyc[0]), 10);
        else
            chk("delay_events", 32'(rise_cyc.size()), 2);
        flush();

        // Ready stall: valid held with stable payload, one handshake
        fill_rom(16'hFFFF);
        rom[0] = 16'h1280;
        stall = 10;
        exp_q.push_back(16'h1280);
        run_pass("stall", -1);
        end_checks("stall", 1, 0, 1, 1);
        chk("stall_rises", 32'(rise_cyc.size()), 1);
        flush();

        // Two NACKs then ACK
        nack_q.push_back(1'b1); nack_q.push_back(1'b1);
        repeat (3) exp_q.push_back(16'h1280);
        run_pass("retry_ok", -1);
        end_checks("retry_ok", 1, 0, 1, 3);
        flush();

        // Four NACKs exhaust retries
        repeat (4) nack_q.push_back(1'b1);
        repeat (4) exp_q.push_back(16'h1280);
        run_pass("retry_err", -1);
        end_checks("retry_err", 0, 1, 0, 4);
        chk("retry_err_addr", 32'(rom_addr), 0);
        flush();

        // Reset in WAIT_DONE, then a clean restart
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
        exp_q.push_back(16'h1280);
        pulse_start();
        wait_hs("rst_wd", 1);
        do_reset("rst_wd");
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
        run_pass("rst_wd_again", -1);
        end_checks("rst_wd_again", 1, 0, 2, 2);
        flush();

        // Reset mid-DELAY, then a clean restart
        fill_rom(16'hFFFF);
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h4010; rom[3] = 16'hFFFF;
        exp_q.push_back(16'h1280);
        pulse_start();
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 500 && !seen; i++) begin
                @(negedge clk); #3;
                if (done_cyc.size() >= 1) seen = 1'b1;
            end
            chk("rst_dly_seen", 32'(seen), 1);
        end
        repeat (3) @(negedge clk);
        do_reset("rst_dly");
        exp_q.push_back(16'h1280); exp_q.push_back(16'h4010);
        run_pass("rst_dly_again", -1);
        end_checks("rst_dly_again", 1, 0, 2, 2);
        flush();

        // No END word: implicit termination after the last address; start while busy ignored
        fill_rom(16'h0000);
        repeat (8) exp_q.push_back(16'h0000);
        run_pass("full", 3);
        end_checks("full", 1, 0, 8, 8);
        chk("full_addr", 32'(rom_addr), 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ov7670_config_seq.md
Name: ov7670_config_seq

Overview:
- Sequences the OV7670 register-configuration ROM. On `start` it walks the synchronous config ROM from address 0 and decodes each 16-bit word.
- It issues one register write per entry to the SCCB master through a valid/ready command handshake, then waits for completion.
- It honours delay and end-of-list marker entries, and retries NACKed writes.
- It sits between the camera-init ROM and the SCCB master, ahead of the pixel capture path.

Parameters:
- ADDRW, 8, ROM address width; the ROM holds 2**ADDRW words.
- DELAY_CYCLES, 250000, clk cycles spent on a delay entry (10 ms at 25 MHz); must be >= 1.
- MAX_RETRY, 3, re-issues allowed per entry after a NACK.
- END_WORD, 16'hFFFF, end-of-list marker.
- DELAY_WORD, 16'hFFF0, delay marker.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse that begins a configuration pass.
- rom_addr  out  ADDRW  ROM address, registered.
- rom_data  in  16  ROM output; valid one clk after rom_addr is registered. Bits [15:8] are the register, bits [7:0] the value.
- cmd_valid  out  1  write request to the SCCB master.
- cmd_ready  in  1  SCCB master accepts the request.
- cmd_reg  out  8  register address of the write.
- cmd_data  out  8  register value of the write.
- cmd_done  in  1  one-cycle pulse when the SCCB write finishes.
- cmd_nack  in  1  qualifies cmd_done; 1 means the camera did not acknowledge.
- busy  out  1  a pass is in progress.
- done  out  1  the pass completed successfully; sticky.
- error  out  1  retries were exhausted; sticky.
- write_count  out  ADDRW+1  number of acknowledged writes in the current pass.

Behaviour:
- Reset values: rom_addr=0, cmd_valid=0, cmd_reg=0, cmd_data=0, busy=0, done=0, error=0, write_count=0, retry counter=0, delay counter=0, state=IDLE.
- Reset mid-pass aborts immediately. cmd_valid is low the cycle after rst. The SCCB master shares rst.
- IDLE / DONE / ERR, on start:
  - clear done, error and write_count;
  - rom_addr<=0, retry counter<=0;
  - go to FETCH; busy=1 from the next cycle.
- While busy, start is ignored.
- FETCH: one cycle, waiting out the ROM latency, then go to DECODE.
- DECODE samples rom_data:
  - END_WORD -> DONE;
  - DELAY_WORD -> DELAY, counter loaded with DELAY_CYCLES-1;
  - any other word -> ISSUE, with cmd_reg<=rom_data[15:8] and cmd_data<=rom_data[7:0].
- ISSUE:
  - cmd_valid=1, and cmd_reg/cmd_data are held stable until the handshake;
  - on cmd_valid&&cmd_ready, cmd_valid drops the next cycle and the state goes to WAIT_DONE;
  - cmd_valid never drops without a handshake.
- WAIT_DONE, on cmd_done:
  - nack=0: write_count+1, retry counter<=0, ADVANCE;
  - nack=1 and retry counter<MAX_RETRY: retry counter+1, back to ISSUE with the same cmd_reg/cmd_data;
  - nack=1 and retry counter==MAX_RETRY: go to ERR. MAX_RETRY=0 means no retries.
- cmd_done outside WAIT_DONE is ignored.
- DELAY: count down to 0, then ADVANCE. The state occupies exactly DELAY_CYCLES cycles.
- ADVANCE (a transition action, not a state):
  - if rom_addr==2**ADDRW-1, go to DONE (the list is implicitly terminated);
  - otherwise rom_addr+1 and go to FETCH.
- DONE: busy=0, done=1.
- ERR: busy=0, error=1. rom_addr holds the failing entry index for debug.
- done and error are mutually exclusive.
- start in the same cycle as the final transition into DONE or ERR is ignored.
- write_count saturates at 2**ADDRW.
- Throughput per normal entry: FETCH(1) + DECODE(1) + ISSUE(>=1) + WAIT_DONE(SCCB time).

Test Plan:
- ROM = {0x1280, 0x1101, 0xFFFF}, ready always 1, done/nack=0 3 cycles after accept, start pulse -> cmd writes (0x12,0x80) then (0x11,0x01) in order; done=1, write_count=2, busy=0; the END word issues no command.
- ROM = {0x1280, 0xFFF0, 0x4010, 0xFFFF}, DELAY_CYCLES=5 -> exactly 5 cycles in DELAY between completion of the first write and the FETCH of entry 2; 2 writes total.
- cmd_ready held low 10 cycles during the first write -> cmd_valid stays high with reg/data stable; exactly one handshake occurs.
- First entry NACKed twice then ACKed, MAX_RETRY=3 -> (0x12,0x80) issued 3 times; done=1, write_count=1. NACKed 4 times -> error=1, done=0, rom_addr=0, busy=0.
- rst asserted while in WAIT_DONE and again mid-DELAY -> all outputs at reset values the next cycle; a following start restarts from address 0.
- ROM full of 0x0000 with no END word, ADDRW=3 -> 8 writes, then done=1, write_count=8; a start pulse while busy has no effect.
